arb_output_buffer: RTL and testbench
====================================

Name: arb_output_buffer

Overview:
Sits directly downstream of the arbitrated FIFO stage and consumes its one-hot grant vector and data_out word.
- Encodes the grant into a requestor index and buffers {index, data} pairs in a small FIFO.
- Presents them on a valid/ready interface.
- Drives a stall signal back upstream so the arbiter withholds grants before the buffer overflows.

Parameters:
NUM_REQS, 4, number of requestors (width of gnt); 2 or more.
WIDTH, 8, data word width (matches arbiter data_out).
DEPTH, 4, buffer entries; power of 2, 2 or more.
IDXW, $clog2(NUM_REQS), requestor index width; derived, not to be overridden.

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-low (state cleared on a clk edge while rst==0)
gnt  input  NUM_REQS  one-hot grant from arbiter; each set bit marks one valid data_in word this cycle
data_in  input  WIDTH  arbiter data_out, valid when gnt!=0
out_ready  input  1  downstream accepts head entry
out_valid  output  1  head entry present
out_data  output  WIDTH  head data
out_idx  output  IDXW  requestor index of head entry
stall  output  1  upstream must not grant next cycle
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: grant dropped because buffer full

Behaviour:
- Reset (rst==0 at edge): wr_ptr, rd_ptr, count=0, overflow=0. Consequently out_valid=0 and stall=0; out_data/out_idx are don't-care while out_valid=0. Reset mid-operation discards all entries; a gnt in the reset cycle is ignored.
- push = (gnt!=0). pop = out_valid && out_ready.
- Index encode: lowest set bit of gnt. Multi-hot gnt is illegal upstream; the buffer stores the lowest index.
- Write: on push, if accepted, mem[wr_ptr] <= {enc(gnt), data_in} and wr_ptr increments mod DEPTH.
- Acceptance: push accepted iff count<DEPTH, or count==DEPTH and pop in the same cycle (simultaneous pop frees the slot).
- Drop: a push that is not accepted is dropped and overflow<=1. overflow stays set until reset.
- Read: out_valid = (count!=0). out_data/out_idx = mem[rd_ptr], a combinational read of registered storage. On pop, rd_ptr increments mod DEPTH.
- Latency: an entry pushed at edge N is visible on out_* after edge N, i.e. 1 cycle. No same-cycle bypass when empty.
- count update per cycle: +1 on accepted push without pop; -1 on pop without push; unchanged on both or neither.
- Pointers wrap naturally (log2(DEPTH) bits). count is the sole full/empty discriminator.
- stall = (count >= DEPTH-1), purely combinational from count. This leaves one slot for a grant issued in the same cycle stall rises. A compliant upstream therefore never causes overflow.
- pop when empty is impossible (out_valid=0); out_ready is ignored in that case.

Optional Feature:
Macro OBUF_ONEHOT_CHK_EN.
- Defined:
  - Adds output gnt_err (1 bit, reset 0), sticky-set the first cycle gnt has more than one bit set. Cleared only by reset.
  - Adds an immediate assertion (under FORMAL) that gnt is zero or one-hot, so the formal top can assume or assert it.
- Undefined: no gnt_err port, no assertion; multi-hot handled by lowest-index rule only.

Test Plan:
(params 4/8/4 throughout)
- Reset: hold rst=0 two cycles with gnt=4'b0010 -> out_valid=0, count=0, stall=0, overflow=0 after release.
- Single transfer: gnt=4'b0100, data_in=8'hA5 for one cycle, out_ready=0 -> next cycle out_valid=1, out_idx=2, out_data=8'hA5, count=1. Then out_ready=1 -> following cycle out_valid=0.
- Fill/stall: four consecutive grants gnt=0001,0010,0100,1000 with data 11,22,33,44, out_ready=0 -> stall rises when count=3. Count reaches 4; drain returns idx 0..3 and data 11,22,33,44 in order.
- Overflow and simultaneous: at count=4 with out_ready=0, gnt=0001 -> overflow=1, count stays 4. Repeat at count=4 with out_ready=1 -> accepted, count stays 4, overflow unchanged.
- Wrap: ten push/pop pairs at rate 1 with out_ready=1 -> data preserved in order across pointer wrap, count toggles between 0 and 1.
- With OBUF_ONEHOT_CHK_EN: gnt=4'b0110 -> stored idx=1, gnt_err=1 next cycle and remains 1 until rst=0.

Source files
------------

// File: rtl/arb_output_buffer.sv
// rtl/arb_output_buffer.sv - grant-index encoder plus {idx,data} FIFO with upstream stall
// Optional OBUF_ONEHOT_CHK_EN adds sticky gnt_err for multi-hot grants.
module arb_output_buffer #(
   parameter int NUM_REQS = 4,
   parameter int WIDTH    = 8,
   parameter int DEPTH    = 4,
   localparam int IDXW    = $clog2(NUM_REQS),
   localparam int CW      = $clog2(DEPTH) + 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REQS-1:0] gnt,
   input  logic [WIDTH-1:0]    data_in,
   input  logic                out_ready,
   output logic                out_valid,
   output logic [WIDTH-1:0]    out_data,
   output logic [IDXW-1:0]     out_idx,
   output logic                stall,
   output logic [CW-1:0]       count,
`ifdef OBUF_ONEHOT_CHK_EN
   output logic                gnt_err,
`endif
   output logic                overflow
);
   localparam int PW = $clog2(DEPTH);

   logic [IDXW+WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic [IDXW-1:0]       enc;
   logic                  push, pop, full, accept;

   // Lowest set bit wins, so an illegal multi-hot grant still yields a defined index.
   always_comb begin
      enc = '0;
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
         if (gnt[i]) enc = IDXW'(i);
      end
   end

   assign push   = (gnt != '0);
   assign pop    = out_valid && out_ready;
   assign full   = (count_q == CW'(DEPTH));
   assign accept = push && (!full || pop);

   always_comb begin
      wr_ptr_d   = accept ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      overflow_d = overflow_q || (push && !accept);
      count_d    = count_q;
      case ({accept, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset; count alone decides which entries are meaningful.
   always_ff @(posedge clk) begin
      if (rst && accept) mem_q[wr_ptr_q] <= {enc, data_in};
   end

   assign out_valid           = (count_q != '0);
   assign {out_idx, out_data} = mem_q[rd_ptr_q];
   assign count               = count_q;
   assign overflow            = overflow_q;
   // One spare slot absorbs a grant issued in the same cycle stall rises.
   assign stall               = (count_q >= CW'(DEPTH - 1));

`ifdef OBUF_ONEHOT_CHK_EN
   logic gnt_err_q;
   always_ff @(posedge clk) begin
      if (!rst) gnt_err_q <= 1'b0;
      else if ((gnt & (gnt - NUM_REQS'(1))) != '0) gnt_err_q <= 1'b1;
   end
   assign gnt_err = gnt_err_q;
`ifdef FORMAL
   always_comb begin
      if (rst) assert ($onehot0(gnt));
   end
`endif
`endif
endmodule

// File: tb/tb_arb_output_buffer.sv
// tb/tb_arb_output_buffer.sv - scoreboard bench for arb_output_buffer (4 reqs, 8 bit, depth 4)
module tb_arb_output_buffer;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] gnt = '0;
   logic [7:0] data_in = '0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic [1:0] out_idx;
   logic       stall;
   logic [2:0] count;
   logic       overflow;
`ifdef OBUF_ONEHOT_CHK_EN
   logic       gnt_err;
`endif

   arb_output_buffer #(.NUM_REQS(4), .WIDTH(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .gnt(gnt), .data_in(data_in), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx), .stall(stall),
      .count(count),
`ifdef OBUF_ONEHOT_CHK_EN
      .gnt_err(gnt_err),
`endif
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         errors = 0;
   logic [9:0] exp_q [$];
   int         mdl_cnt = 0;
   bit         mdl_ovf = 1'b0;
   bit         mdl_gerr = 1'b0;
   bit         chk_en = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] lowest(input logic [3:0] g);
      for (int i = 0; i < 4; i++) if (g[i]) return 2'(i);
      return 2'd0;
   endfunction

   // Monitor: state checks every cycle, scoreboard pop whenever a transfer is presented.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("count", 32'(count), 32'(mdl_cnt));
         chk("out_valid", 32'(out_valid), 32'(mdl_cnt != 0));
         chk("stall", 32'(stall), 32'(mdl_cnt >= 3));
         chk("overflow", 32'(overflow), 32'(mdl_ovf));
`ifdef OBUF_ONEHOT_CHK_EN
         chk("gnt_err", 32'(gnt_err), 32'(mdl_gerr));
`endif
         if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pop", 32'(1), 32'(0));
            end else begin
               logic [9:0] e;
               e = exp_q.pop_front();
               chk("out_idx", 32'(out_idx), 32'(e[9:8]));
               chk("out_data", 32'(out_data), 32'(e[7:0]));
            end
         end
      end
   end

   // Drive one cycle and advance the reference model across the edge.
   task automatic step(input logic [3:0] g, input logic [7:0] d, input logic r);
      bit pop_w, push_w, acc;
      gnt = g; data_in = d; out_ready = r;
      pop_w  = (mdl_cnt != 0) && r;
      push_w = (g != 0);
      acc    = push_w && (mdl_cnt < 4 || pop_w);
      @(posedge clk); #1;
      if (acc) exp_q.push_back({lowest(g), d});
      if (push_w && !acc) mdl_ovf = 1'b1;
      if ($countones(g) > 1) mdl_gerr = 1'b1;
      mdl_cnt = mdl_cnt + int'(acc) - int'(pop_w);
   endtask

   task automatic do_reset();
      rst = 1'b0; gnt = 4'b0010; data_in = 8'hFF; out_ready = 1'b0;
      @(posedge clk); #1;
      exp_q.delete(); mdl_cnt = 0; mdl_ovf = 1'b0; mdl_gerr = 1'b0; chk_en = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; gnt = '0;
   endtask

   initial begin
      @(posedge clk); #1;
      do_reset();
      chk("rst_valid", 32'(out_valid), 32'(0));
      chk("rst_count", 32'(count), 32'(0));

      step(4'b0100, 8'hA5, 1'b0);
      chk("single_idx", 32'(out_idx), 32'(2));
      chk("single_data", 32'(out_data), 32'hA5);
      step(4'b0000, 8'h00, 1'b1);
      chk("single_drained", 32'(out_valid), 32'(0));

      step(4'b0001, 8'h11, 1'b0);
      step(4'b0010, 8'h22, 1'b0);
      step(4'b0100, 8'h33, 1'b0);
      chk("stall_at3", 32'(stall), 32'(1));
      step(4'b1000, 8'h44, 1'b0);
      chk("full_count", 32'(count), 32'(4));
      step(4'b0001, 8'h55, 1'b0);
      chk("ovf_set", 32'(overflow), 32'(1));
      step(4'b0001, 8'h66, 1'b1);
      chk("simul_count", 32'(count), 32'(4));
      for (int i = 0; i < 5; i++) step(4'b0000, 8'h00, 1'b1);

      for (int i = 0; i < 10; i++) begin
         step(4'(1 << (i % 4)), 8'(8'h80 + i), 1'b1);
         step(4'b0000, 8'h00, 1'b1);
      end

      do_reset();
      chk("rst2_ovf", 32'(overflow), 32'(0));
      for (int i = 0; i < 400; i++) begin
         logic [3:0] g;
         int sel;
         sel = $urandom_range(0, 9);
         if (sel < 3)       g = 4'b0000;
         else if (sel == 9) g = 4'($urandom_range(0, 15));
         else               g = 4'(1 << $urandom_range(0, 3));
         step(g, 8'($urandom), 1'($urandom_range(0, 2) != 0));
         if (i == 200) do_reset();
      end
      for (int i = 0; i < 6; i++) step(4'b0000, 8'h00, 1'b1);
      chk("sb_empty", 32'(exp_q.size()), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
